// File: rtl/debug_cmd_sequencer_pkg.sv
// Shared types and constants for the debug command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debug_cmd_sequencer_pkg;

  localparam int BYTE     = 8;
  localparam int DWORD    = 32;
  localparam int RB_ADDR  = 5;
  localparam int ADDR     = 5;
  localparam int IM_DEPTH = 256;
  localparam int NB_ST    = 10;
  localparam int IM_AW    = $clog2(IM_DEPTH);

  localparam int BYTES_PER_WORD = DWORD / BYTE;
  localparam int RF_WORDS       = 1 << RB_ADDR;
  localparam int DM_WORDS       = 1 << ADDR;
  // PC word + register file + data memory, every word sent as 4 bytes
  localparam int DUMP_BYTES     = BYTES_PER_WORD * (1 + RF_WORDS + DM_WORDS);

  localparam logic [BYTE-1:0] CMD_LOAD = 8'd1;
  localparam logic [BYTE-1:0] CMD_RUN  = 8'd2;
  localparam logic [BYTE-1:0] CMD_STEP = 8'd3;
  localparam logic [BYTE-1:0] CMD_DUMP = 8'd4;

  // One-hot state encoding, bit order fixed for the o_state debug output
  typedef enum logic [NB_ST-1:0] {
    ST_IDLE    = 10'b00_0000_0001,
    ST_LOAD_IM = 10'b00_0000_0010,
    ST_RUN     = 10'b00_0000_0100,
    ST_STEP    = 10'b00_0000_1000,
    ST_DUMP_PC = 10'b00_0001_0000,
    ST_DUMP_RF = 10'b00_0010_0000,
    ST_DUMP_DM = 10'b00_0100_0000,
    ST_TX_SEND = 10'b00_1000_0000,
    ST_TX_WAIT = 10'b01_0000_0000,
    ST_DONE    = 10'b10_0000_0000
  } state_t;

  // Which dump section the word being serialized belongs to
  typedef enum logic [1:0] {
    SEC_PC = 2'd0,
    SEC_RF = 2'd1,
    SEC_DM = 2'd2
  } sect_t;

endpackage

// File: rtl/debug_cmd_sequencer_if.sv
// Host/CPU-side signal bundle of the debug command sequencer.
// Latency: n/a (wires only). Backpressure: n/a.
// master = sequencer (drives o_*), slave = UART/CPU side (drives i_*).
interface debug_cmd_sequencer_if;
  import debug_cmd_sequencer_pkg::*;

  logic              i_rx_done;
  logic [BYTE-1:0]   i_rx_data;
  logic              i_tx_done;
  logic              i_halt;
  logic [DWORD-1:0]  i_pc;
  logic [DWORD-1:0]  i_rf_data;
  logic [DWORD-1:0]  i_dm_data;

  logic              o_im_wr_en;
  logic [IM_AW-1:0]  o_im_addr;
  logic [BYTE-1:0]   o_im_data;
  logic              o_cpu_enable;
  logic [RB_ADDR-1:0] o_rf_addr;
  logic [ADDR-1:0]   o_dm_addr;
  logic [BYTE-1:0]   o_tx_data;
  logic              o_tx_start;
  logic              o_halt;
  logic [NB_ST-1:0]  o_state;

  modport master (
    input  i_rx_done, i_rx_data, i_tx_done, i_halt, i_pc, i_rf_data, i_dm_data,
    output o_im_wr_en, o_im_addr, o_im_data, o_cpu_enable, o_rf_addr, o_dm_addr,
           o_tx_data, o_tx_start, o_halt, o_state
  );

  modport slave (
    output i_rx_done, i_rx_data, i_tx_done, i_halt, i_pc, i_rf_data, i_dm_data,
    input  o_im_wr_en, o_im_addr, o_im_data, o_cpu_enable, o_rf_addr, o_dm_addr,
           o_tx_data, o_tx_start, o_halt, o_state
  );

endinterface

// File: rtl/debug_cmd_sequencer_dbg_word_serializer.sv
// Latches a 32-bit word and presents it one byte at a time, MSB first.
// Latency: byte 0 visible the cycle after load; each adv shifts in the next byte.
// Backpressure: only moves on adv (UART tx_done); done pulses with the adv of byte 3.
// Ports: load/word capture, adv step, out_dat current byte, last = byte 3 showing.
module dbg_word_serializer
  import debug_cmd_sequencer_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             load,
  input  logic [DWORD-1:0] word,
  input  logic             adv,
  output logic [BYTE-1:0]  out_dat,
  output logic             last,
  output logic             done
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] CNT_LAST = CW'(BYTES_PER_WORD - 1);

  logic [DWORD-1:0] shift_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= word;
      cnt_q   <= '0;
    end else if (adv) begin
      shift_q <= {shift_q[DWORD-BYTE-1:0], {BYTE{1'b0}}};
      cnt_q   <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign out_dat = shift_q[DWORD-1 -: BYTE];
  assign last    = (cnt_q == CNT_LAST);
  assign done    = adv && last;

endmodule

// File: rtl/debug_cmd_sequencer.sv
// Host command sequencer: IM load, run/step CPU gating, PC/RF/DM byte dump.
// Latency: command -> state next edge; IM write 1 cycle after rx byte; tx_start 2 cycles after tx_done.
// Backpressure: dump waits on i_tx_done per byte; rx bytes outside IDLE/LOAD_IM are dropped.
// Ports: i_clock, i_reset (sync, active high), bus = debug_cmd_sequencer_if.master.
module debug_cmd_sequencer
  import debug_cmd_sequencer_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset,
  debug_cmd_sequencer_if.master  bus
);

  localparam logic [IM_AW-1:0] IM_LAST = IM_AW'(IM_DEPTH - 1);
  localparam logic [ADDR-1:0]  RF_LAST = ADDR'(RF_WORDS - 1);
  localparam logic [ADDR-1:0]  DM_LAST = ADDR'(DM_WORDS - 1);

  state_t           state, state_nxt;
  sect_t            sect;
  logic [IM_AW-1:0] im_cnt;
  logic [ADDR-1:0]  word_cnt;

  logic             ser_load;
  logic [DWORD-1:0] ser_word;
  logic             ser_adv;
  logic [BYTE-1:0]  ser_dat;
  logic             ser_last;
  logic             ser_done;

  dbg_word_serializer u_ser (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .load    (ser_load),
    .word    (ser_word),
    .adv     (ser_adv),
    .out_dat (ser_dat),
    .last    (ser_last),
    .done    (ser_done)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ser_load  = 1'b0;
    ser_word  = '0;
    ser_adv   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_rx_done) begin
          case (bus.i_rx_data)
            CMD_LOAD: state_nxt = ST_LOAD_IM;
            CMD_RUN:  state_nxt = ST_RUN;
            CMD_STEP: state_nxt = ST_STEP;
            CMD_DUMP: state_nxt = ST_DUMP_PC;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_IM: begin
        if (bus.i_rx_done && (im_cnt == IM_LAST)) state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.i_halt) state_nxt = ST_DUMP_PC;
      end
      ST_STEP: state_nxt = ST_DUMP_PC;
      // The DUMP_* states are the latch cycle right before the word's first TX_SEND
      ST_DUMP_PC: begin
        ser_load  = 1'b1;
        ser_word  = bus.i_pc;
        state_nxt = ST_TX_SEND;
      end
      ST_DUMP_RF: begin
        ser_load  = 1'b1;
        ser_word  = bus.i_rf_data;
        state_nxt = ST_TX_SEND;
      end
      ST_DUMP_DM: begin
        ser_load  = 1'b1;
        ser_word  = bus.i_dm_data;
        state_nxt = ST_TX_SEND;
      end
      ST_TX_SEND: state_nxt = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (bus.i_tx_done) begin
          ser_adv = 1'b1;
          if (!ser_last) begin
            state_nxt = ST_TX_SEND;
          end else begin
            case (sect)
              SEC_PC:  state_nxt = ST_DUMP_RF;
              SEC_RF:  state_nxt = (word_cnt == RF_LAST) ? ST_DUMP_DM : ST_DUMP_RF;
              default: state_nxt = (word_cnt == DM_LAST) ? ST_DONE : ST_DUMP_DM;
            endcase
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A halt already present suppresses the enable in the same cycle, so a RUN
  // entered with halt high, or a STEP under halt, never advances the pipeline.
  assign bus.o_cpu_enable = ((state == ST_RUN) || (state == ST_STEP)) && !bus.i_halt;
  assign bus.o_state      = state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      im_cnt         <= '0;
      word_cnt       <= '0;
      sect           <= SEC_PC;
      bus.o_im_wr_en <= 1'b0;
      bus.o_im_addr  <= '0;
      bus.o_im_data  <= '0;
      bus.o_rf_addr  <= '0;
      bus.o_dm_addr  <= '0;
      bus.o_tx_data  <= '0;
      bus.o_tx_start <= 1'b0;
      bus.o_halt     <= 1'b0;
    end else begin
      bus.o_halt     <= bus.i_halt;
      bus.o_im_wr_en <= 1'b0;
      // Registered start/data: keeps 2 cycles between tx_done and the next start
      bus.o_tx_start <= (state == ST_TX_SEND);
      if (state == ST_TX_SEND) bus.o_tx_data <= ser_dat;

      if ((state == ST_LOAD_IM) && bus.i_rx_done) begin
        bus.o_im_wr_en <= 1'b1;
        bus.o_im_addr  <= im_cnt;
        bus.o_im_data  <= bus.i_rx_data;
        im_cnt         <= (im_cnt == IM_LAST) ? '0 : im_cnt + 1'b1;
      end

      if (state == ST_DUMP_PC) begin
        sect     <= SEC_PC;
        word_cnt <= '0;
      end

      // Read addresses move to the next word as soon as the current one is
      // latched, giving the 1-cycle-latency RF/DM reads a whole word of slack.
      // After the last word they return to 0, ready for the next dump.
      if (state == ST_DUMP_RF)
        bus.o_rf_addr <= (word_cnt == RF_LAST) ? '0 : RB_ADDR'(word_cnt + 1'b1);
      if (state == ST_DUMP_DM)
        bus.o_dm_addr <= (word_cnt == DM_LAST) ? '0 : ADDR'(word_cnt + 1'b1);

      if (ser_done) begin
        case (sect)
          SEC_PC: begin
            sect     <= SEC_RF;
            word_cnt <= '0;
          end
          SEC_RF: begin
            if (word_cnt == RF_LAST) begin
              sect     <= SEC_DM;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
          default: begin
            word_cnt <= (word_cnt == DM_LAST) ? '0 : word_cnt + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Self-checking bench for debug_cmd_sequencer: scoreboard queues for IM writes
// and TX bytes, UART/RF/DM responder models, randomized data and delays.
module tb_debug_cmd_sequencer;
  import debug_cmd_sequencer_pkg::*;

  localparam logic [9:0] S_IDLE = 10'd1;
  localparam logic [9:0] S_LOAD = 10'd2;
  localparam logic [9:0] S_RUN  = 10'd4;
  localparam logic [9:0] S_TXW  = 10'd256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_cmd_sequencer_if bus ();

  debug_cmd_sequencer dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tx_cnt = 0;
  int wr_cnt = 0;
  int en_cnt = 0;
  bit hold_tx = 1'b0;

  logic [15:0] exp_im[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] rf_mem[32];
  logic [31:0] dm_mem[32];
  logic [7:0]  last_tx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=%0h required=none", name, act);
  endtask

  // Scoreboard monitor: samples on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_cpu_enable) en_cnt++;
      if (bus.o_im_wr_en) begin
        wr_cnt++;
        if (exp_im.size() == 0) unexpected("im_write", {bus.o_im_addr, bus.o_im_data});
        else chk("im_write", {bus.o_im_addr, bus.o_im_data}, exp_im.pop_front());
      end
      if (bus.o_tx_start) begin
        tx_cnt++;
        if (exp_tx.size() == 0) unexpected("tx_byte", bus.o_tx_data);
        else chk("tx_byte", bus.o_tx_data, exp_tx.pop_front());
      end
    end
  end

  // UART transmitter model: tx_done a few cycles after each start
  initial begin
    int d;
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start) begin
        d = $urandom_range(1, 6);
        repeat (d) @(posedge clk);
        while (hold_tx) @(posedge clk);
        #1 bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1 bus.i_tx_done = 1'b0;
      end
    end
  end

  // RF / DM read ports: data follows the address one cycle later
  initial begin
    logic [4:0] a_rf;
    logic [4:0] a_dm;
    bus.i_rf_data = '0;
    bus.i_dm_data = '0;
    forever begin
      @(negedge clk);
      a_rf = bus.o_rf_addr;
      a_dm = bus.o_dm_addr;
      @(posedge clk);
      #1;
      bus.i_rf_data = rf_mem[a_rf];
      bus.i_dm_data = dm_mem[a_dm];
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 bus.i_rx_done = 1'b1;
    bus.i_rx_data = b;
    @(posedge clk);
    #1 bus.i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference dump: PC, then RF words, then DM words, each MSB first
  task automatic prep_dump();
    logic [31:0] w;
    bus.i_pc = $urandom;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      dm_mem[i] = $urandom;
    end
    for (int k = 0; k < 65; k++) begin
      if (k == 0)       w = bus.i_pc;
      else if (k <= 32) w = rf_mem[k - 1];
      else              w = dm_mem[k - 33];
      for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
    end
    last_tx = dm_mem[31][7:0];
  endtask

  task automatic wait_dump(input string name, input int tx0);
    int k;
    k = 0;
    while (exp_tx.size() != 0 && k < 4000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({name, "_remaining"}, exp_tx.size(), 0);
    k = 0;
    while (bus.o_state != S_IDLE && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_idle"}, bus.o_state, S_IDLE);
    chk({name, "_byte_count"}, tx_cnt - tx0, 260);
  endtask

  initial begin
    int tx0;
    int wr0;
    int t1;
    int k;
    logic [7:0] v;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    bus.i_halt    = 1'b0;
    bus.i_pc      = '0;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = '0;
      dm_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    chk("rst_state", bus.o_state, S_IDLE);
    chk("rst_im_wr_en", bus.o_im_wr_en, 0);
    chk("rst_im_addr", bus.o_im_addr, 0);
    chk("rst_im_data", bus.o_im_data, 0);
    chk("rst_cpu_enable", bus.o_cpu_enable, 0);
    chk("rst_rf_addr", bus.o_rf_addr, 0);
    chk("rst_dm_addr", bus.o_dm_addr, 0);
    chk("rst_tx_data", bus.o_tx_data, 0);
    chk("rst_tx_start", bus.o_tx_start, 0);
    chk("rst_halt", bus.o_halt, 0);

    // full IM load, byte i carries value i
    wr0 = wr_cnt;
    send_byte(8'h01);
    chk("load_enter", bus.o_state, S_LOAD);
    for (int i = 0; i < 256; i++) begin
      exp_im.push_back({8'(i), 8'(i)});
      send_byte(8'(i));
      idle($urandom_range(0, 2));
    end
    idle(3);
    chk("load_writes", wr_cnt - wr0, 256);
    chk("load_exit", bus.o_state, S_IDLE);
    chk("load_queue", exp_im.size(), 0);

    // unknown command leaves everything alone
    send_byte(8'h07);
    idle(2);
    chk("bad_cmd_state", bus.o_state, S_IDLE);
    chk("bad_cmd_im_wr_en", bus.o_im_wr_en, 0);
    chk("bad_cmd_im_addr", bus.o_im_addr, 8'hff);
    chk("bad_cmd_im_data", bus.o_im_data, 8'hff);
    chk("bad_cmd_cpu_enable", bus.o_cpu_enable, 0);
    chk("bad_cmd_tx_start", bus.o_tx_start, 0);
    chk("bad_cmd_tx_data", bus.o_tx_data, last_tx);

    // reset in the middle of a load
    send_byte(8'h01);
    for (int i = 0; i < 100; i++) begin
      v = 8'($urandom);
      exp_im.push_back({8'(i), v});
      send_byte(v);
      idle($urandom_range(0, 2));
    end
    idle(1);
    do_reset();
    chk("midload_rst_state", bus.o_state, S_IDLE);
    chk("midload_rst_wr_en", bus.o_im_wr_en, 0);
    chk("midload_rst_im_addr", bus.o_im_addr, 0);

    // RUN, halt raised 40 cycles later, then full dump
    prep_dump();
    tx0 = tx_cnt;
    en_cnt = 0;
    send_byte(8'h02);
    chk("run_enter", bus.o_state, S_RUN);
    repeat (40) @(posedge clk);
    #1 bus.i_halt = 1'b1;
    wait_dump("run_dump", tx0);
    chk("run_enable_40_41", (en_cnt >= 40) && (en_cnt <= 41), 1);
    chk("run_halt_copy", bus.o_halt, 1);
    bus.i_halt = 1'b0;
    idle(2);

    // STEP without halt: exactly one enabled cycle
    prep_dump();
    tx0 = tx_cnt;
    en_cnt = 0;
    send_byte(8'h03);
    wait_dump("step_dump", tx0);
    chk("step_enable_cycles", en_cnt, 1);

    // STEP with halt: no enabled cycle
    bus.i_halt = 1'b1;
    idle(2);
    prep_dump();
    tx0 = tx_cnt;
    en_cnt = 0;
    send_byte(8'h03);
    wait_dump("step_halt_dump", tx0);
    chk("step_halt_enable_cycles", en_cnt, 0);
    bus.i_halt = 1'b0;
    idle(2);

    // dump with stalled UART and a stray load command
    prep_dump();
    tx0 = tx_cnt;
    send_byte(8'h04);
    k = 0;
    while ((tx_cnt - tx0) < 10 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    hold_tx = 1'b1;
    chk("hold_progress", (tx_cnt - tx0) >= 10, 1);
    k = 0;
    while (bus.o_state != S_TXW && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    idle(2);
    wr0 = wr_cnt;
    t1 = tx_cnt;
    send_byte(8'h01);
    idle(500);
    chk("hold_no_im_write", wr_cnt - wr0, 0);
    chk("hold_no_tx_start", tx_cnt - t1, 0);
    chk("hold_state", bus.o_state, S_TXW);
    hold_tx = 1'b0;
    wait_dump("hold_dump", tx0);
    chk("final_tx_data", bus.o_tx_data, last_tx);
    chk("final_rf_addr", bus.o_rf_addr, 0);
    chk("final_im_queue", exp_im.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
